// File: rtl/env_pkg.sv
// Shared types and helpers for the envelope sequencer.
// Optional feature macro used by the top: ENV_LOOP_EN (stage looping).
package env_pkg;

    // Gain fractional bits at the default configuration (256 = unity).
    localparam int unsigned GainFracDefault = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StSustain
    } env_state_t;

    // Clamp a signed value to the range of a w-bit two's complement number.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int unsigned         w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/env_gain_mult.sv
// Registered saturating signed x unsigned multiply with fixed-point shift.
module env_gain_mult
    import env_pkg::*;
#(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned GAIN_W    = 16,
    parameter int unsigned GAIN_FRAC = GainFracDefault
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic signed [WIDTH-1:0] sample_i,
    input  logic [GAIN_W-1:0]       gain_i,
    output logic signed [WIDTH-1:0] sample_o
);

    // One extra bit so the unsigned gain stays positive in the signed product.
    localparam int unsigned ProdW = WIDTH + GAIN_W + 1;

    logic signed [ProdW-1:0] a_ext;
    logic signed [ProdW-1:0] g_ext;
    logic signed [ProdW-1:0] prod;
    logic signed [63:0]      shifted;
    logic signed [WIDTH-1:0] out_d;
    logic signed [WIDTH-1:0] out_q;

    // Scale, shift and clamp the product; hold the last result between enables.
    always_comb begin
        a_ext   = ProdW'(sample_i);
        g_ext   = ProdW'(gain_i);
        prod    = a_ext * g_ext;
        shifted = 64'(prod >>> GAIN_FRAC);
        out_d   = out_q;
        if (en_i) begin
            out_d = WIDTH'(sat_signed(shifted, WIDTH));
        end
    end

    // Output register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign sample_o = out_q;

endmodule

// File: rtl/envelope_sequencer.sv
// Multi-stage envelope generator and gain stage.
// Define ENV_LOOP_EN to add loop_stage/loop_en: after the last stage the
// envelope jumps back to loop_stage instead of ending in idle.
module envelope_sequencer
    import env_pkg::*;
#(
    parameter int unsigned N_STAGES  = 8,
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned GAIN_W    = 16,
    parameter int unsigned DUR_W     = 24,
    parameter int unsigned GAIN_FRAC = GainFracDefault,
    localparam int unsigned IDX_W    = $clog2(N_STAGES)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       sample_en,
    input  logic                       retrigger,
    input  logic                       gate,
    input  logic [IDX_W-1:0]           sustain_stage,
    input  logic [N_STAGES*GAIN_W-1:0] stage_gain,
    input  logic [N_STAGES*DUR_W-1:0]  stage_dur,
`ifdef ENV_LOOP_EN
    input  logic [IDX_W-1:0]           loop_stage,
    input  logic                       loop_en,
`endif
    input  logic signed [WIDTH-1:0]    in,
    output logic signed [WIDTH-1:0]    out,
    output logic [GAIN_W-1:0]          gain_out,
    output logic [IDX_W-1:0]           stage_idx,
    output logic                       active
);

    logic [GAIN_W-1:0] gain_arr [N_STAGES];
    logic [DUR_W-1:0]  dur_arr  [N_STAGES];

    env_state_t        state_d, state_q;
    logic [IDX_W-1:0]  idx_d, idx_q;
    logic [IDX_W-1:0]  idx_next;
    logic [DUR_W-1:0]  cnt_d, cnt_q;
    logic [GAIN_W-1:0] gain_d, gain_q;
    logic              active_d, active_q;
    logic              adv;

    // Unpack stage tables; a zero duration still lasts one sample.
    always_comb begin
        for (int i = 0; i < int'(N_STAGES); i++) begin
            gain_arr[i] = stage_gain[i*GAIN_W +: GAIN_W];
            dur_arr[i]  = stage_dur[i*DUR_W +: DUR_W];
            if (dur_arr[i] == '0) begin
                dur_arr[i] = DUR_W'(1);
            end
        end
    end

    // Stage sequencing: retrigger wins, otherwise act once per sample.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        gain_d   = gain_q;
        adv      = 1'b0;
        idx_next = idx_q + IDX_W'(1);
        if (retrigger) begin
            state_d = StRun;
            idx_d   = '0;
            cnt_d   = dur_arr[0];
        end else if (sample_en) begin
            unique case (state_q)
                StIdle: gain_d = '0;
                StRun: begin
                    gain_d = gain_arr[idx_q];
                    if (cnt_q > DUR_W'(1)) begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end else if (idx_q == sustain_stage && gate) begin
                        state_d = StSustain;
                    end else begin
                        adv = 1'b1;
                    end
                end
                StSustain: begin
                    gain_d = gain_arr[idx_q];
                    adv    = !gate;
                end
                default: state_d = StIdle;
            endcase
            if (adv) begin
                if (idx_q < IDX_W'(N_STAGES - 1)) begin
                    state_d = StRun;
                    idx_d   = idx_next;
                    cnt_d   = dur_arr[idx_next];
                end
`ifdef ENV_LOOP_EN
                else if (loop_en) begin
                    state_d = StRun;
                    idx_d   = loop_stage;
                    cnt_d   = dur_arr[loop_stage];
                end
`endif
                else begin
                    state_d = StIdle;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
        end
        active_d = (state_d != StIdle);
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cnt_q    <= '0;
            gain_q   <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            gain_q   <= gain_d;
            active_q <= active_d;
        end
    end

    // The multiplier sees gain_q before this sample's update: gain lags one sample.
    env_gain_mult #(
        .WIDTH    (WIDTH),
        .GAIN_W   (GAIN_W),
        .GAIN_FRAC(GAIN_FRAC)
    ) u_gain_mult (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .en_i    (sample_en),
        .sample_i(in),
        .gain_i  (gain_q),
        .sample_o(out)
    );

    assign gain_out  = gain_q;
    assign stage_idx = idx_q;
    assign active    = active_q;

endmodule
